// File: rtl/continuous_monitoring_system_pkg.sv
// continuous_monitoring_system_pkg: shared control map, range bases and FSM encoding for the trace window
package continuous_monitoring_system_pkg;
  localparam int CTRL_ADDR_WIDTH = 8;
  localparam int CTRL_DATA_WIDTH = 64;
  localparam logic [31:0] WFI_INSTRUCTION = 32'h1050_0073;
  localparam logic [CTRL_ADDR_WIDTH-1:0] RANGE_LOWER_BASE = 8'h20;
  localparam logic [CTRL_ADDR_WIDTH-1:0] RANGE_UPPER_BASE = 8'h40;
  typedef enum logic [CTRL_ADDR_WIDTH-1:0] {
    A_START_EN        = 8'h00,
    A_END_EN          = 8'h01,
    A_START_ADDR      = 8'h02,
    A_END_ADDR        = 8'h03,
    A_RANGE_MASK      = 8'h04,
    A_TLAST_INTERVAL  = 8'h05,
    A_HALT_ON_FULL_EN = 8'h06,
    A_ARBITRARY_HALT  = 8'h07,
    A_WFI_STOPPED     = 8'h08,
    A_STATE           = 8'h09,
    A_EMIT_TOTAL      = 8'h0A
  } trace_window_addr_t;
  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_TRACING = 2'd1,
    ST_STOPPED = 2'd2
  } tw_state_t;
endpackage

// File: rtl/addr_range_match.sv
// addr_range_match: inclusive unsigned [lower, upper] hit for one enabled range
module addr_range_match #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] lower,
  input  logic [XLEN-1:0] upper,
  input  logic            enable,
  output logic            hit
);
  assign hit = enable && pc >= lower && pc <= upper;
endmodule

// File: rtl/trace_window_ctrl.sv
// trace_window_ctrl: start/end triggered PC trace window with range filter, TLAST pacing and CPU halt control
module trace_window_ctrl
  import continuous_monitoring_system_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter int NUM_RANGES      = 4,
  parameter int TLAST_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [XLEN-1:0]            pc,
  input  logic [31:0]                instr,
  input  logic                       pc_valid,
  input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
  input  logic                       ctrl_we,
  output logic [CTRL_DATA_WIDTH-1:0] ctrl_rdata,
  input  logic                       fifo_full,
  output logic                       trace_valid,
  output logic [XLEN-1:0]            trace_pc,
  output logic                       trace_last,
  output logic                       halt_cpu,
  output logic [1:0]                 state
);
  tw_state_t                  state_q, state_d;
  logic                       start_en_q, end_en_q, halt_on_full_en_q, arbitrary_halt_q;
  logic [XLEN-1:0]            start_addr_q, end_addr_q;
  logic [NUM_RANGES-1:0]      range_mask_q, range_hits;
  logic [XLEN-1:0]            lower_q [NUM_RANGES];
  logic [XLEN-1:0]            upper_q [NUM_RANGES];
  logic [TLAST_CNT_WIDTH-1:0] tlast_interval_q, cnt_q, cnt_d;
  logic [63:0]                total_q;
  logic                       trace_valid_q, trace_last_q;
  logic [XLEN-1:0]            trace_pc_q;
  logic [CTRL_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                       range_hit, is_wfi, start_hit, end_hit, emit, end_evt;
  logic                       wr_tlast, wr_release, int_last;
  for (genvar i = 0; i < NUM_RANGES; i++) begin : g_range
    addr_range_match #(.XLEN(XLEN)) u_match (
      .pc     (pc),
      .lower  (lower_q[i]),
      .upper  (upper_q[i]),
      .enable (range_mask_q[i]),
      .hit    (range_hits[i])
    );
  end
  assign range_hit  = range_mask_q == '0 || |range_hits;
  assign is_wfi     = pc_valid && instr == WFI_INSTRUCTION;
  assign start_hit  = !start_en_q || pc == start_addr_q;
  assign end_hit    = end_en_q && pc == end_addr_q;
  assign wr_tlast   = ctrl_we && ctrl_addr == A_TLAST_INTERVAL;
  assign wr_release = ctrl_we && ctrl_addr == A_WFI_STOPPED && ctrl_wdata == '0;
  // WFI outranks every trigger; in ARMED a start match wins over a coincident end match
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    end_evt = 1'b0;
    if (is_wfi)
      state_d = ST_STOPPED;
    else if (pc_valid && state_q == ST_ARMED && start_hit) begin
      state_d = ST_TRACING;
      emit    = range_hit;
    end else if (pc_valid && state_q == ST_TRACING) begin
      end_evt = end_hit;
      state_d = end_hit ? ST_ARMED : ST_TRACING;
      emit    = range_hit;
    end else if (state_q == ST_STOPPED && wr_release)
      state_d = ST_ARMED;
  end
  assign int_last = tlast_interval_q != '0 && cnt_q == tlast_interval_q - TLAST_CNT_WIDTH'(1);
  assign cnt_d    = (wr_tlast || end_evt) ? '0 : !emit ? cnt_q : int_last ? '0 : cnt_q + TLAST_CNT_WIDTH'(1);
  always_comb begin
    rdata_d = '0;
    case (ctrl_addr)
      A_START_EN:        rdata_d = CTRL_DATA_WIDTH'(start_en_q);
      A_END_EN:          rdata_d = CTRL_DATA_WIDTH'(end_en_q);
      A_START_ADDR:      rdata_d = CTRL_DATA_WIDTH'(start_addr_q);
      A_END_ADDR:        rdata_d = CTRL_DATA_WIDTH'(end_addr_q);
      A_RANGE_MASK:      rdata_d = CTRL_DATA_WIDTH'(range_mask_q);
      A_TLAST_INTERVAL:  rdata_d = CTRL_DATA_WIDTH'(tlast_interval_q);
      A_HALT_ON_FULL_EN: rdata_d = CTRL_DATA_WIDTH'(halt_on_full_en_q);
      A_ARBITRARY_HALT:  rdata_d = CTRL_DATA_WIDTH'(arbitrary_halt_q);
      A_WFI_STOPPED:     rdata_d = CTRL_DATA_WIDTH'(state_q == ST_STOPPED);
      A_STATE:           rdata_d = CTRL_DATA_WIDTH'(state_q);
      A_EMIT_TOTAL:      rdata_d = CTRL_DATA_WIDTH'(total_q);
      default:           ;
    endcase
    for (int i = 0; i < NUM_RANGES; i++) begin
      if (ctrl_addr == RANGE_LOWER_BASE + CTRL_ADDR_WIDTH'(i)) rdata_d = CTRL_DATA_WIDTH'(lower_q[i]);
      if (ctrl_addr == RANGE_UPPER_BASE + CTRL_ADDR_WIDTH'(i)) rdata_d = CTRL_DATA_WIDTH'(upper_q[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_ARMED;
      start_en_q        <= 1'b0;
      end_en_q          <= 1'b0;
      start_addr_q      <= '0;
      end_addr_q        <= '0;
      range_mask_q      <= '0;
      tlast_interval_q  <= '0;
      halt_on_full_en_q <= 1'b0;
      arbitrary_halt_q  <= 1'b0;
      cnt_q             <= '0;
      total_q           <= '0;
      trace_valid_q     <= 1'b0;
      trace_last_q      <= 1'b0;
      trace_pc_q        <= '0;
      rdata_q           <= '0;
      for (int i = 0; i < NUM_RANGES; i++) begin
        lower_q[i] <= '0;
        upper_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      total_q       <= total_q + {63'b0, emit};
      trace_valid_q <= emit;
      trace_last_q  <= emit && (end_evt || int_last);
      rdata_q       <= rdata_d;
      if (emit) trace_pc_q <= pc;
      if (ctrl_we) begin
        case (ctrl_addr)
          A_START_EN:        start_en_q        <= ctrl_wdata[0];
          A_END_EN:          end_en_q          <= ctrl_wdata[0];
          A_START_ADDR:      start_addr_q      <= XLEN'(ctrl_wdata);
          A_END_ADDR:        end_addr_q        <= XLEN'(ctrl_wdata);
          A_RANGE_MASK:      range_mask_q      <= ctrl_wdata[NUM_RANGES-1:0];
          A_TLAST_INTERVAL:  tlast_interval_q  <= TLAST_CNT_WIDTH'(ctrl_wdata);
          A_HALT_ON_FULL_EN: halt_on_full_en_q <= ctrl_wdata[0];
          A_ARBITRARY_HALT:  arbitrary_halt_q  <= ctrl_wdata[0];
          default:           ;
        endcase
        for (int i = 0; i < NUM_RANGES; i++) begin
          if (ctrl_addr == RANGE_LOWER_BASE + CTRL_ADDR_WIDTH'(i)) lower_q[i] <= XLEN'(ctrl_wdata);
          if (ctrl_addr == RANGE_UPPER_BASE + CTRL_ADDR_WIDTH'(i)) upper_q[i] <= XLEN'(ctrl_wdata);
        end
      end
    end
  end
  assign halt_cpu    = (halt_on_full_en_q & fifo_full) | arbitrary_halt_q;
  assign trace_valid = trace_valid_q;
  assign trace_last  = trace_last_q;
  assign trace_pc    = trace_pc_q;
  assign ctrl_rdata  = rdata_q;
  assign state       = state_q;
endmodule

// File: doc/trace_window_ctrl.md
TRACE_WINDOW_CTRL -- requirements
Module: trace_window_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning PC width.
REQ-002 SHALL have parameter NUM_RANGES, default 4 (1..16), meaning the number of independent monitored address ranges.
REQ-003 SHALL have parameter TLAST_CNT_WIDTH, default 32, meaning the TLAST interval counter width.
REQ-004 SHALL have ports: clk in 1 (system clock); rst in 1 (reset); one clock, reset synchronous and active-high.
REQ-005 SHALL have ports: pc in XLEN (committed PC); instr in 32 (committed instruction); pc_valid in 1 (commit strobe).
REQ-006 SHALL have ports: ctrl_addr in CTRL_ADDR_WIDTH; ctrl_wdata in CTRL_DATA_WIDTH; ctrl_we in 1; ctrl_rdata out CTRL_DATA_WIDTH (control read/write).
REQ-007 SHALL have ports: fifo_full in 1 (downstream FIFO full); trace_valid out 1; trace_pc out XLEN; trace_last out 1 (TLAST); halt_cpu out 1; state out 2.

Function
REQ-008 SHALL implement FSM ARMED(0), TRACING(1), STOPPED(2); the state output shows the current encoding.
REQ-009 ARMED->TRACING SHALL occur on pc_valid when start trigger disabled, or when pc == start_addr; the triggering PC is emitted.
REQ-010 TRACING->ARMED SHALL occur on pc_valid with end trigger enabled and pc == end_addr; that PC is emitted with trace_last=1.
REQ-011 In ARMED with start and end both matching the same PC, start SHALL win: go to TRACING, emit, end ignored that cycle.
REQ-012 pc_valid with instr == WFI_INSTRUCTION SHALL move any state to STOPPED (highest priority); the WFI PC is not emitted.
REQ-013 STOPPED->ARMED SHALL occur only on a control write of 0 to WFI_STOPPED; reads of WFI_STOPPED return 1 in STOPPED, otherwise 0.
REQ-014 Range hit SHALL be: range mask == 0, or pc within [lower_i, upper_i] inclusive (unsigned) for any enabled i; lower > upper never hits.
REQ-015 A PC SHALL be emitted iff pc_valid, post-transition state is TRACING (or per REQ-010), and range hit.
REQ-016 Emission SHALL be registered: trace_valid/trace_pc/trace_last valid exactly 1 cycle after the pc_valid cycle, held 1 cycle.
REQ-017 Emit counter SHALL increment per emitted item; trace_last=1 when counter reaches tlast_interval-1, then counter clears; interval 0 disables interval TLAST.
REQ-018 The counter SHALL also clear on every REQ-010 end event and on any write to TLAST_INTERVAL.
REQ-019 halt_cpu SHALL be combinational: (halt_on_full_en & fifo_full) | arbitrary_halt.
REQ-020 Writes SHALL take effect next cycle; writes to unmapped/read-only addresses are ignored.
REQ-021 ctrl_rdata SHALL be registered (1-cycle latency); unmapped addresses read 0; narrower fields zero-extended.
REQ-022 Map: START_EN, END_EN, START_ADDR, END_ADDR, RANGE_MASK (NUM_RANGES bits), TLAST_INTERVAL, HALT_ON_FULL_EN, ARBITRARY_HALT, WFI_STOPPED, STATE (RO), EMIT_TOTAL (RO, 64-bit wrapping); RANGE_LOWER at 0x20+i, RANGE_UPPER at 0x40+i, i<NUM_RANGES.
REQ-023 A control write and a pc_valid in the same cycle SHALL evaluate pc against pre-write register values.

Reset
REQ-024 On rst: state ARMED; all control registers, counters, trace_valid, trace_last, trace_pc, ctrl_rdata = 0.
REQ-025 rst asserted mid-trace SHALL drop trace_valid next cycle; no pending item is emitted after reset.

Structure
REQ-026 The address enum (trace_window_addr_t), range base constants 0x20/0x40 and FSM state typedef SHALL live in continuous_monitoring_system_pkg.
REQ-027 Per-range compare SHALL be a sub-module addr_range_match (pc, lower, upper, enable -> hit), instantiated NUM_RANGES times via generate.

Verification
REQ-028 Start=0x1000 enabled, end disabled; PCs 0xFF0,0x1000,0x1004 -> only 0x1000,0x1004 emitted, each 1 cycle later; state=1.
REQ-029 TRACING, end=0x2000; PC 0x2000 -> emitted with trace_last=1; state=0; EMIT_TOTAL +1.
REQ-030 Range0=[0x100,0x1FF] enabled, tracing; PCs 0xFF,0x100,0x1FF,0x200 -> only 0x100,0x1FF emitted; mask 0 -> all four.
REQ-031 TLAST_INTERVAL=3, 7 emits -> trace_last on emits 3 and 6 only.
REQ-032 WFI committed while TRACING -> not emitted, state=2, WFI_STOPPED reads 1; write 0 -> state=0.
REQ-033 halt_on_full_en=1, fifo_full toggles -> halt_cpu follows same cycle; arbitrary_halt=1 -> halt_cpu=1 regardless; rst mid-trace -> all outputs 0 next cycle.
